// File: rtl/imm_ext_pipe_pkg.sv
// Shared format codes and opcode constants for the immediate generator.
// Codes I..J keep their historical values; Z, Sh and None take the next free codes.
package imm_ext_pipe_pkg;

    typedef enum logic [2:0] {
        EXT_IMM_I    = 3'd0,
        EXT_IMM_S    = 3'd1,
        EXT_IMM_B    = 3'd2,
        EXT_IMM_U    = 3'd3,
        EXT_IMM_J    = 3'd4,
        EXT_IMM_Z    = 3'd5,
        EXT_IMM_SH   = 3'd6,
        EXT_IMM_NONE = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

endpackage

// File: rtl/imm_ext_pipe_core.sv
// Combinational format selection and immediate extraction.
// Extraction is done at 64 bits and truncated to XLEN.
module imm_ext_pipe_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic [31:0]     i_ins,
    input  logic [2:0]      i_sel_ext,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_is_shift;
    imm_fmt_e    w_fmt;
    logic        w_illegal;
    logic        w_sh_wide;
    logic [63:0] w_imm64;

    assign w_opc      = i_ins[6:0];
    assign w_f3       = i_ins[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    always_comb begin
        w_fmt     = EXT_IMM_NONE;
        w_illegal = 1'b0;
        w_sh_wide = 1'b0;
        if (AUTO_DECODE) begin
            // w_opc includes ins[1:0], so compressed encodings fall into default.
            case (w_opc)
                OPC_LUI, OPC_AUIPC: w_fmt = EXT_IMM_U;
                OPC_JAL:            w_fmt = EXT_IMM_J;
                OPC_JALR, OPC_LOAD: w_fmt = EXT_IMM_I;
                OPC_STORE:          w_fmt = EXT_IMM_S;
                OPC_BRANCH:         w_fmt = EXT_IMM_B;
                OPC_OP_IMM: begin
                    w_fmt     = w_is_shift ? EXT_IMM_SH : EXT_IMM_I;
                    w_sh_wide = (XLEN == 64);
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) w_fmt = w_is_shift ? EXT_IMM_SH : EXT_IMM_I;
                    else            w_illegal = 1'b1;
                end
                OPC_SYSTEM:         w_fmt = w_f3[2] ? EXT_IMM_Z : EXT_IMM_I;
                OPC_OP, OPC_MISC_MEM: w_fmt = EXT_IMM_NONE;
                OPC_OP_32: begin
                    if (XLEN != 64) w_illegal = 1'b1;
                end
                default:            w_illegal = 1'b1;
            endcase
        end else begin
            w_sh_wide = (XLEN == 64);
            case (i_sel_ext)
                EXT_IMM_I, EXT_IMM_S, EXT_IMM_B, EXT_IMM_U,
                EXT_IMM_J, EXT_IMM_Z, EXT_IMM_SH, EXT_IMM_NONE:
                    w_fmt = imm_fmt_e'(i_sel_ext);
                default: w_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_imm64 = 64'd0;
        if (!w_illegal) begin
            case (w_fmt)
                EXT_IMM_I:  w_imm64 = {{52{i_ins[31]}}, i_ins[31:20]};
                EXT_IMM_S:  w_imm64 = {{52{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
                EXT_IMM_B:  w_imm64 = {{52{i_ins[31]}}, i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
                EXT_IMM_U:  w_imm64 = {{32{i_ins[31]}}, i_ins[31:12], 12'd0};
                EXT_IMM_J:  w_imm64 = {{44{i_ins[31]}}, i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
                EXT_IMM_Z:  w_imm64 = {59'd0, i_ins[19:15]};
                EXT_IMM_SH: w_imm64 = {58'd0, w_sh_wide & i_ins[25], i_ins[24:20]};
                default:    w_imm64 = 64'd0;
            endcase
        end
    end

    assign o_imm     = w_imm64[XLEN-1:0];
    assign o_fmt     = w_illegal ? EXT_IMM_NONE : w_fmt;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator: decode core feeding a two-entry skid buffer
// (output register plus one skid slot), 1-cycle latency, full throughput.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [2:0]      in_sel_ext,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_ext_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] w_core_imm;
    imm_fmt_e        w_core_fmt;
    logic            w_core_illegal;

    imm_ext_pipe_core #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_core (
        .i_ins     (in_ins),
        .i_sel_ext (in_sel_ext),
        .o_imm     (w_core_imm),
        .o_fmt     (w_core_fmt),
        .o_illegal (w_core_illegal)
    );

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    imm_fmt_e        r_out_fmt;
    logic            r_out_illegal;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    imm_fmt_e        r_skid_fmt;
    logic            r_skid_illegal;

    // Handshake: a word moves on a side only in a cycle where valid and ready are
    // both high; out_* hold while out_valid && !out_ready; in_ready = skid slot empty.
    logic w_in_fire;
    logic w_out_free;
    logic w_load_out;
    logic w_load_skid;

    assign w_in_fire   = in_valid && in_ready;
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_load_out  = w_out_free && (r_skid_valid || w_in_fire);
    assign w_load_skid = !w_out_free && w_in_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_fmt      <= EXT_IMM_NONE;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_fmt     <= EXT_IMM_NONE;
            r_skid_illegal <= 1'b0;
        end else begin
            // Payloads load regardless of flush; only the valid bits are squashed.
            if (w_load_out) begin
                if (r_skid_valid) begin
                    r_out_imm     <= r_skid_imm;
                    r_out_fmt     <= r_skid_fmt;
                    r_out_illegal <= r_skid_illegal;
                end else begin
                    r_out_imm     <= w_core_imm;
                    r_out_fmt     <= w_core_fmt;
                    r_out_illegal <= w_core_illegal;
                end
            end
            if (w_load_skid) begin
                r_skid_imm     <= w_core_imm;
                r_skid_fmt     <= w_core_fmt;
                r_skid_illegal <= w_core_illegal;
            end
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                r_out_valid  <= r_skid_valid || w_in_fire;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_ins;
    logic [2:0]  in_sel_ext;
    logic        flush;
    logic        out_ready;

    logic        in_ready_32, out_valid_32, out_illegal_32;
    logic [31:0] out_imm_32;
    logic [2:0]  out_fmt_32;
    logic        in_ready_64, out_valid_64, out_illegal_64;
    logic [63:0] out_imm_64;
    logic [2:0]  out_fmt_64;

    int n_checks = 0;
    int n_errors = 0;

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_32),
        .in_ins(in_ins), .in_sel_ext(in_sel_ext), .flush(flush),
        .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(out_imm_32),
        .out_fmt(out_fmt_32), .out_illegal(out_illegal_32)
    );

    imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_64),
        .in_ins(in_ins), .in_sel_ext(in_sel_ext), .flush(flush),
        .out_valid(out_valid_64), .out_ready(out_ready), .out_imm(out_imm_64),
        .out_fmt(out_fmt_64), .out_illegal(out_illegal_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Format codes: I=0 S=1 B=2 U=3 J=4 Z=5 Sh=6 None=7
    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] ins,
                           input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                           input logic [63:0] i64, input logic [2:0] f64, input logic l64);
        vec_t v;
        v.name = n; v.ins = ins;
        v.imm32 = i32; v.fmt32 = f32; v.ill32 = l32;
        v.imm64 = i64; v.fmt64 = f64; v.ill64 = l64;
        vecs.push_back(v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid32"}, 64'(out_valid_32), 64'd0);
        check({tag, "_imm32"},   64'(out_imm_32),   64'd0);
        check({tag, "_fmt32"},   64'(out_fmt_32),   64'd7);
        check({tag, "_ill32"},   64'(out_illegal_32), 64'd0);
        check({tag, "_rdy32"},   64'(in_ready_32),  64'd1);
        check({tag, "_valid64"}, 64'(out_valid_64), 64'd0);
        check({tag, "_imm64"},   out_imm_64,        64'd0);
        check({tag, "_rdy64"},   64'(in_ready_64),  64'd1);
    endtask

    function automatic logic [31:0] addi(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ins = '0; in_sel_ext = '0;
        flush = 1'b0; out_ready = 1'b1;

        add_vec("addi",   32'hFFF0_0093, 32'hFFFF_FFFF, 3'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 0);
        add_vec("slli",   32'h01F0_1013, 32'h0000_001F, 3'd6, 0, 64'h1F, 3'd6, 0);
        add_vec("srai",   32'h41F0_D013, 32'h0000_001F, 3'd6, 0, 64'h1F, 3'd6, 0);
        add_vec("slli63", 32'h03F0_1013, 32'h0000_001F, 3'd6, 0, 64'h3F, 3'd6, 0);
        add_vec("slliw",  32'h03F0_101B, 32'h0,         3'd7, 1, 64'h1F, 3'd6, 0);
        add_vec("jal",    32'hFE1F_F06F, 32'hFFFF_FFE0, 3'd4, 0, 64'hFFFF_FFFF_FFFF_FFE0, 3'd4, 0);
        add_vec("csrrwi", 32'h0002_D073, 32'h0000_0005, 3'd5, 0, 64'h5, 3'd5, 0);
        add_vec("zero",   32'h0000_0000, 32'h0,         3'd7, 1, 64'h0, 3'd7, 1);
        add_vec("op32",   32'h0000_003B, 32'h0,         3'd7, 1, 64'h0, 3'd7, 0);
        add_vec("add",    32'h0000_0033, 32'h0,         3'd7, 0, 64'h0, 3'd7, 0);
        add_vec("lui",    32'h1234_50B7, 32'h1234_5000, 3'd3, 0, 64'h1234_5000, 3'd3, 0);
        add_vec("luineg", 32'h8000_00B7, 32'h8000_0000, 3'd3, 0, 64'hFFFF_FFFF_8000_0000, 3'd3, 0);
        add_vec("sw",     32'hFE11_2E23, 32'hFFFF_FFFC, 3'd1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 0);
        add_vec("beq",    32'h0000_0463, 32'h0000_0008, 3'd2, 0, 64'h8, 3'd2, 0);
        add_vec("rvc",    32'h0000_0091, 32'h0,         3'd7, 1, 64'h0, 3'd7, 1);

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        step();

        // Back-to-back words with out_ready=1: each appears one cycle after acceptance.
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_ins   = vecs[i].ins;
            step();
            check({vecs[i].name, "_v32"},   64'(out_valid_32),   64'd1);
            check({vecs[i].name, "_imm32"}, 64'(out_imm_32),     64'(vecs[i].imm32));
            check({vecs[i].name, "_fmt32"}, 64'(out_fmt_32),     64'(vecs[i].fmt32));
            check({vecs[i].name, "_ill32"}, 64'(out_illegal_32), 64'(vecs[i].ill32));
            check({vecs[i].name, "_imm64"}, out_imm_64,          vecs[i].imm64);
            check({vecs[i].name, "_fmt64"}, 64'(out_fmt_64),     64'(vecs[i].fmt64));
            check({vecs[i].name, "_ill64"}, 64'(out_illegal_64), 64'(vecs[i].ill64));
        end
        in_valid = 1'b0;
        step();
        check("idle_valid", 64'(out_valid_32), 64'd0);

        // Stall: three back-to-back words, only two fit.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = addi(1); step();
        check("stall_rdy1", 64'(in_ready_32), 64'd1);
        in_ins = addi(2); step();
        check("stall_rdy2", 64'(in_ready_32), 64'd0);
        in_ins = addi(3); step();
        check("stall_hold_imm", 64'(out_imm_32), 64'd1);
        check("stall_hold_v",   64'(out_valid_32), 64'd1);
        check("stall_rdy3",     64'(in_ready_32), 64'd0);
        out_ready = 1'b1; step();
        check("drain_w2", 64'(out_imm_32), 64'd2);
        check("drain_rdy", 64'(in_ready_32), 64'd1);
        step();
        in_valid = 1'b0;
        check("drain_w3",   64'(out_imm_32), 64'd3);
        check("drain_w3_v", 64'(out_valid_32), 64'd1);
        step();
        check("drain_empty", 64'(out_valid_32), 64'd0);

        // Flush with both slots full and a word offered in the flush cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = addi(4); step();
        in_ins = addi(5); step();
        check("flush_pre_rdy", 64'(in_ready_32), 64'd0);
        out_ready = 1'b1; flush = 1'b1; in_ins = addi(6); step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid_32), 64'd0);
        check("flush_rdy",   64'(in_ready_32),  64'd1);
        step();
        check("flush_discard", 64'(out_valid_32), 64'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ins = addi(7); step();
        in_ins = 32'hFFF0_0093; step();
        in_valid = 1'b0;
        check("prereset_v", 64'(out_valid_32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("postrst_v", 64'(out_valid_32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
